// File: rtl/gpio_bank_apb_if.sv
// gpio_bank_apb_if: APB3 slave bus bundle for one GPIO bank.
// master drives address/control/wdata; slave returns prdata/pready/pslverr.
interface gpio_bank_apb_if #(
  parameter int PADDR_WIDTH = 4,
  parameter int DATA_WIDTH  = 8
);
  logic [PADDR_WIDTH-1:0] paddr;
  logic                   pselx;
  logic                   penable;
  logic                   pwrite;
  logic [DATA_WIDTH-1:0]  pwdata;
  logic [DATA_WIDTH-1:0]  prdata;
  logic                   pready;
  logic                   pslverr;

  modport master (
    output paddr, pselx, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pselx, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/gpio_bank_apb.sv
// gpio_bank_apb: APB register bank driving PIN_NUM pads with atomic
// set/clr/tgl, input sync and level/edge irqs (W1C status).
// Ports: pclk, presetn (sync, active low), apb (slave modport),
// a/oe/pu/pd pad controls, y async pad input, irq bank interrupt.
module gpio_bank_apb #(
  parameter int PIN_NUM     = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int PADDR_WIDTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               pclk,
  input  logic               presetn,
  gpio_bank_apb_if.slave     apb,
  output logic [PIN_NUM-1:0] a,
  output logic [PIN_NUM-1:0] oe,
  output logic [PIN_NUM-1:0] pu,
  output logic [PIN_NUM-1:0] pd,
  input  logic [PIN_NUM-1:0] y,
  output logic               irq
);

  localparam int AW = PADDR_WIDTH;
  localparam logic [AW-1:0] A_OUT  = AW'(4'h0);
  localparam logic [AW-1:0] A_OE   = AW'(4'h1);
  localparam logic [AW-1:0] A_PU   = AW'(4'h2);
  localparam logic [AW-1:0] A_PD   = AW'(4'h3);
  localparam logic [AW-1:0] A_IN   = AW'(4'h4);
  localparam logic [AW-1:0] A_SET  = AW'(4'h5);
  localparam logic [AW-1:0] A_CLR  = AW'(4'h6);
  localparam logic [AW-1:0] A_TGL  = AW'(4'h7);
  localparam logic [AW-1:0] A_EN   = AW'(4'h8);
  localparam logic [AW-1:0] A_TYP  = AW'(4'h9);
  localparam logic [AW-1:0] A_POL  = AW'(4'hA);
  localparam logic [AW-1:0] A_BOTH = AW'(4'hB);
  localparam logic [AW-1:0] A_STAT = AW'(4'hC);

  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] ARM_MAX = CW'(SYNC_STAGES + 1);

  logic [PIN_NUM-1:0] out_q,  out_d;
  logic [PIN_NUM-1:0] oe_q,   oe_d;
  logic [PIN_NUM-1:0] pu_q,   pu_d;
  logic [PIN_NUM-1:0] pd_q,   pd_d;
  logic [PIN_NUM-1:0] en_q,   en_d;
  logic [PIN_NUM-1:0] typ_q,  typ_d;
  logic [PIN_NUM-1:0] pol_q,  pol_d;
  logic [PIN_NUM-1:0] both_q, both_d;
  logic [PIN_NUM-1:0] stat_q, stat_d;
  logic [PIN_NUM-1:0] yprev_q;
  logic [SYNC_STAGES-1:0][PIN_NUM-1:0] sync_q;
  logic [CW-1:0] arm_q, arm_d;

  logic [PIN_NUM-1:0] ysync;
  logic [PIN_NUM-1:0] rise, fall;
  logic [PIN_NUM-1:0] edge_ev, lvl_ev, ev;
  logic [PIN_NUM-1:0] wd, w1c, rsel;
  logic               armed, wen, rsv;

  assign ysync = sync_q[SYNC_STAGES-1];
  assign armed = (arm_q == ARM_MAX);
  assign arm_d = armed ? arm_q : arm_q + CW'(1);

  assign rise = ysync & ~yprev_q;
  assign fall = ~ysync & yprev_q;

  // BOTH overrides POL for edge pins
  assign edge_ev = (both_q & (rise | fall))
                 | (~both_q & pol_q & rise)
                 | (~both_q & ~pol_q & fall);
  assign lvl_ev  = ~(ysync ^ pol_q);

  // edges masked until sync chain and yprev hold real pad data
  assign ev = (typ_q & edge_ev & {PIN_NUM{armed}})
            | (~typ_q & lvl_ev);

  assign wen = apb.pselx & apb.penable & apb.pwrite;
  assign wd  = apb.pwdata[PIN_NUM-1:0];
  assign rsv = (apb.paddr > A_STAT);

  always_comb begin
    out_d  = out_q;
    oe_d   = oe_q;
    pu_d   = pu_q;
    pd_d   = pd_q;
    en_d   = en_q;
    typ_d  = typ_q;
    pol_d  = pol_q;
    both_d = both_q;
    w1c    = '0;
    if (wen) begin
      case (apb.paddr)
        A_OUT:   out_d  = wd;
        A_OE:    oe_d   = wd;
        A_PU:    pu_d   = wd;
        A_PD:    pd_d   = wd;
        A_SET:   out_d  = out_q | wd;
        A_CLR:   out_d  = out_q & ~wd;
        A_TGL:   out_d  = out_q ^ wd;
        A_EN:    en_d   = wd;
        A_TYP:   typ_d  = wd;
        A_POL:   pol_d  = wd;
        A_BOTH:  both_d = wd;
        A_STAT:  w1c    = wd;
        default: ;
      endcase
    end
    // a new event beats a simultaneous clear
    stat_d = (stat_q & ~w1c) | ev;
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      out_q   <= '0;
      oe_q    <= '0;
      pu_q    <= '0;
      pd_q    <= '0;
      en_q    <= '0;
      typ_q   <= '0;
      pol_q   <= '0;
      both_q  <= '0;
      stat_q  <= '0;
      yprev_q <= '0;
      sync_q  <= '0;
      arm_q   <= '0;
    end else begin
      out_q   <= out_d;
      oe_q    <= oe_d;
      pu_q    <= pu_d;
      pd_q    <= pd_d;
      en_q    <= en_d;
      typ_q   <= typ_d;
      pol_q   <= pol_d;
      both_q  <= both_d;
      stat_q  <= stat_d;
      yprev_q <= ysync;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], y};
      arm_q   <= arm_d;
    end
  end

  always_comb begin
    rsel = '0;
    case (apb.paddr)
      A_OUT:   rsel = out_q;
      A_OE:    rsel = oe_q;
      A_PU:    rsel = pu_q;
      A_PD:    rsel = pd_q;
      A_IN:    rsel = ysync;
      A_EN:    rsel = en_q;
      A_TYP:   rsel = typ_q;
      A_POL:   rsel = pol_q;
      A_BOTH:  rsel = both_q;
      A_STAT:  rsel = stat_q;
      default: rsel = '0;
    endcase
  end

  // zero when unselected so banks can OR onto one return bus
  always_comb begin
    apb.prdata = '0;
    if (apb.pselx && !apb.pwrite) begin
      apb.prdata[PIN_NUM-1:0] = rsel;
    end
  end

  assign apb.pready  = apb.pselx & apb.penable;
  assign apb.pslverr = apb.pselx & apb.penable & rsv;

  assign a   = out_q;
  assign oe  = oe_q;
  assign pd  = pd_q;
  assign pu  = pu_q & ~pd_q;
  assign irq = |(stat_q & en_q);

endmodule

// File: tb/tb_gpio_bank_apb.sv
// tb_gpio_bank_apb: directed + random bench for gpio_bank_apb
// against a per-pin behavioural model of the register bank.
module tb_gpio_bank_apb;
  localparam int PN = 8;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int SS = 2;

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic [PN-1:0] a, oe, pu, pd, y;
  logic          irq;

  int checks = 0;
  int errors = 0;

  gpio_bank_apb_if #(.PADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb();

  gpio_bank_apb #(
    .PIN_NUM(PN), .DATA_WIDTH(DW),
    .PADDR_WIDTH(AW), .SYNC_STAGES(SS)
  ) dut (
    .pclk(pclk), .presetn(presetn), .apb(apb),
    .a(a), .oe(oe), .pu(pu), .pd(pd), .y(y), .irq(irq)
  );

  always #5 pclk = ~pclk;

  // model: register array by address, pad history newest first
  logic [7:0] m_reg [13];
  logic [7:0] m_hist [$];
  int         m_age;

  function automatic logic [7:0] m_read(int adr);
    case (adr)
      0, 1, 2, 3, 8, 9, 10, 11, 12: return m_reg[adr];
      4: return m_hist[SS-1];
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge pclk) begin : mdl
    logic [7:0] ys, yp, ev, clr;
    if (!presetn) begin
      foreach (m_reg[i]) m_reg[i] = 8'h00;
      m_hist.delete();
      repeat (SS + 1) m_hist.push_back(8'h00);
      m_age = 0;
    end else begin
      ys = m_hist[SS-1];
      yp = m_hist[SS];
      for (int p = 0; p < PN; p++) begin
        if (!m_reg[9][p]) ev[p] = (ys[p] == m_reg[10][p]);
        else if (m_age < SS + 1) ev[p] = 1'b0;
        else if (ys[p] == yp[p]) ev[p] = 1'b0;
        else if (m_reg[11][p]) ev[p] = 1'b1;
        else ev[p] = (ys[p] == m_reg[10][p]);
      end
      clr = 8'h00;
      if (apb.pselx && apb.penable && apb.pwrite) begin
        case (int'(apb.paddr))
          0, 1, 2, 3, 8, 9, 10, 11:
            m_reg[int'(apb.paddr)] = apb.pwdata;
          5: m_reg[0] = m_reg[0] | apb.pwdata;
          6: m_reg[0] = m_reg[0] & ~apb.pwdata;
          7: m_reg[0] = m_reg[0] ^ apb.pwdata;
          12: clr = apb.pwdata;
          default: ;
        endcase
      end
      m_reg[12] = (m_reg[12] & ~clr) | ev;
      m_hist.push_front(y);
      void'(m_hist.pop_back());
      if (m_age < 1000) m_age++;
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs();
    chk("a", a, m_reg[0]);
    chk("oe", oe, m_reg[1]);
    chk("pu", pu, m_reg[2] & ~m_reg[3]);
    chk("pd", pd, m_reg[3]);
    chk("irq", irq, |(m_reg[12] & m_reg[8]));
  endtask

  task automatic wr(input logic [3:0] ad, input logic [7:0] d);
    @(negedge pclk);
    apb.pselx = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = ad; apb.pwdata = d;
    @(negedge pclk);
    apb.penable = 1'b1;
    #1;
    chk("wr_pready", apb.pready, 1);
    chk("wr_pslverr", apb.pslverr, (ad > 4'hC));
    @(negedge pclk);
    apb.pselx = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    #1;
  endtask

  task automatic rd(input logic [3:0] ad, output logic [7:0] d);
    @(negedge pclk);
    apb.pselx = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = ad;
    @(negedge pclk);
    apb.penable = 1'b1;
    #1;
    d = apb.prdata;
    chk("rd_data", d, m_read(int'(ad)));
    chk("rd_pready", apb.pready, 1);
    chk("rd_pslverr", apb.pslverr, (ad > 4'hC));
    @(negedge pclk);
    apb.pselx = 1'b0; apb.penable = 1'b0;
    #1;
    chk("idle_prdata", apb.prdata, 0);
    chk("idle_pready", apb.pready, 0);
  endtask

  task automatic do_reset(input logic [7:0] yv);
    @(negedge pclk);
    presetn = 1'b0;
    y = yv;
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    #1;
  endtask

  initial begin
    logic [7:0] v;
    apb.pselx = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0; apb.pwdata = '0;
    y = 8'h00;

    do_reset(8'h00);
    chk("rst_a", a, 8'h00);
    chk("rst_oe", oe, 8'h00);
    chk("rst_pu", pu, 8'h00);
    chk("rst_pd", pd, 8'h00);
    chk("rst_irq", irq, 0);
    for (int ad = 0; ad < 16; ad++) begin
      rd(4'(ad), v);
      if (ad >= 13) chk("rsv_zero", v, 8'h00);
    end

    wr(4'h0, 8'hA5); chk("out_wr", a, 8'hA5);
    wr(4'h5, 8'h0F); chk("out_set", a, 8'hAF);
    wr(4'h6, 8'h80); chk("out_clr", a, 8'h2F);
    wr(4'h7, 8'h03); chk("out_tgl", a, 8'h2C);
    rd(4'h5, v); chk("wo_reads0", v, 8'h00);

    wr(4'h2, 8'hFF);
    wr(4'h3, 8'h0F);
    chk("pu_conf", pu, 8'hF0);
    chk("pd_conf", pd, 8'h0F);

    y = 8'h01;
    rd(4'h4, v); chk("in_sync", v, 8'h01);

    wr(4'h9, 8'h01);
    wr(4'hA, 8'h01);
    wr(4'h8, 8'h01);
    y = 8'h00;
    repeat (4) @(negedge pclk);
    wr(4'hC, 8'hFF);
    chk("irq_clr0", irq, 0);
    y = 8'h01;
    repeat (2) @(negedge pclk);
    #1 chk("irq_not_yet", irq, 0);
    @(negedge pclk);
    #1 chk("irq_rise", irq, 1);
    chk_outs();
    wr(4'hC, 8'h01);
    chk("irq_w1c", irq, 0);

    wr(4'hA, 8'h09);
    wr(4'h8, 8'h08);
    y = 8'h09;
    repeat (4) @(negedge pclk);
    wr(4'hC, 8'h08);
    rd(4'hC, v); chk("lvl_sticky", v[3], 1);
    chk("lvl_irq", irq, 1);
    y = 8'h01;
    repeat (4) @(negedge pclk);
    wr(4'hC, 8'h08);
    rd(4'hC, v); chk("lvl_clr", v[3], 0);
    chk("lvl_irq0", irq, 0);

    y = 8'h00;
    repeat (4) @(negedge pclk);
    wr(4'hC, 8'h01);
    y = 8'h01;
    wr(4'hC, 8'h01);
    rd(4'hC, v); chk("set_wins", v[0], 1);

    do_reset(8'hFF);
    wr(4'h9, 8'hFF);
    wr(4'hB, 8'hFF);
    repeat (2) @(negedge pclk);
    wr(4'hC, 8'hFF);
    rd(4'hC, v); chk("arm_quiet", v, 8'h00);
    y = 8'h7F;
    repeat (4) @(negedge pclk);
    rd(4'hC, v); chk("arm_fall", v, 8'h80);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1: begin
          @(negedge pclk);
          y = 8'($urandom);
        end
        2, 3, 4: wr(4'($urandom_range(0, 15)), 8'($urandom));
        5, 6, 7: rd(4'($urandom_range(0, 15)), v);
        8: begin
          @(negedge pclk);
          #1;
        end
        default: begin
          if ($urandom_range(0, 9) == 0) do_reset(8'($urandom));
          else wr(4'hC, 8'($urandom));
        end
      endcase
      chk_outs();
      chk("pu_pd_excl", pu & pd, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
